// File: rtl/alarm_pkg.sv
// Shared types and BCD time-word layout for the alarm sequencing controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_CLK = 2'd1,
    SET_ALM = 2'd2
  } mode_t;

  localparam int TIME_W = 20;
  localparam int H1_MSB = 19;
  localparam int H1_LSB = 18;
  localparam int H0_MSB = 17;
  localparam int H0_LSB = 14;
  localparam int M1_MSB = 13;
  localparam int M1_LSB = 11;
  localparam int M0_MSB = 10;
  localparam int M0_LSB = 7;
  localparam int S1_MSB = 6;
  localparam int S1_LSB = 4;
  localparam int S0_MSB = 3;
  localparam int S0_LSB = 0;

  // Field-wise equality of two time words; covers all 20 bits.
  function automatic logic time_eq(input logic [TIME_W-1:0] a, input logic [TIME_W-1:0] b);
    return (a[H1_MSB:H1_LSB] == b[H1_MSB:H1_LSB]) &&
           (a[H0_MSB:H0_LSB] == b[H0_MSB:H0_LSB]) &&
           (a[M1_MSB:M1_LSB] == b[M1_MSB:M1_LSB]) &&
           (a[M0_MSB:M0_LSB] == b[M0_MSB:M0_LSB]) &&
           (a[S1_MSB:S1_LSB] == b[S1_MSB:S1_LSB]) &&
           (a[S0_MSB:S0_LSB] == b[S0_MSB:S0_LSB]);
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:     return SET_CLK;
      SET_CLK: return SET_ALM;
      SET_ALM: return RUN;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds countdown: decrements on tick while enabled, pulses expire
// on the tick that takes it from 1 to 0. A load overrides a same-cycle tick.
module sec_countdown #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count_r;

  assign expire = en & tick & (count_r == W'(1));

  // Count register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && tick && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller: edit-mode register and edit routing, alarm
// match detection and the arm/ring/snooze state machine driving the buzzer.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic [19:0] cur_time,
  input  logic [19:0] alarm_time,
  input  logic        mode_btn,
  input  logic [1:0]  edit_btns,
  input  logic        arm_btn,
  input  logic        stop_btn,
  input  logic        snooze_btn,
  output logic [1:0]  clk_edit_btns,
  output logic [1:0]  alm_edit_btns,
  output logic [1:0]  mode,
  output logic        armed,
  output logic        ringing,
  output logic        buzzer
);

  localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW       = $clog2(MAX_SECS + 1);
  localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SECS);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SECS);

  mode_t          mode_r;
  state_t         state_r;
  state_t         state_nxt_s;
  logic           match_s;
  logic           match_q_r;
  logic           hit_s;
  logic           load_s;
  logic [CW-1:0]  load_val_s;
  logic           cnt_en_s;
  logic           expire_s;
  logic           phase_r;
  logic           phase_nxt_s;
  logic           armed_r;
  logic           ringing_r;
  logic           buzzer_r;

  assign mode    = mode_r;
  assign armed   = armed_r;
  assign ringing = ringing_r;
  assign buzzer  = buzzer_r;

  // Edit mode register, stepping RUN -> SET_CLK -> SET_ALM -> RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= RUN;
    end else if (mode_btn) begin
      mode_r <= next_mode(mode_r);
    end else begin
      mode_r <= mode_r;
    end
  end

  // Route edit edges to whichever block is being edited; RUN drops them.
  always_comb begin
    clk_edit_btns = 2'b00;
    alm_edit_btns = 2'b00;
    case (mode_r)
      SET_CLK: clk_edit_btns = edit_btns;
      SET_ALM: alm_edit_btns = edit_btns;
      default: begin
        clk_edit_btns = 2'b00;
        alm_edit_btns = 2'b00;
      end
    endcase
  end

  assign match_s  = time_eq(cur_time, alarm_time);
  // Rising edge only, so stopping inside the matching second cannot retrigger.
  assign hit_s    = match_s & ~match_q_r;
  assign cnt_en_s = (state_r == RINGING) || (state_r == SNOOZE);

  sec_countdown #(
    .W (CW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .tick     (tick_1hz),
    .en       (cnt_en_s),
    .expire   (expire_s)
  );

  // Next state and counter loads; arm > stop > snooze > hit/expiry.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    load_val_s  = RING_LOAD;
    case (state_r)
      IDLE: begin
        if (arm_btn) state_nxt_s = ARMED;
        else         state_nxt_s = IDLE;
      end
      ARMED: begin
        if (arm_btn) begin
          state_nxt_s = IDLE;
        end else if (hit_s) begin
          state_nxt_s = RINGING;
          load_s      = 1'b1;
          load_val_s  = RING_LOAD;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      RINGING: begin
        if (arm_btn) begin
          state_nxt_s = IDLE;
        end else if (stop_btn) begin
          state_nxt_s = ARMED;
        end else if (snooze_btn) begin
          state_nxt_s = SNOOZE;
          load_s      = 1'b1;
          load_val_s  = SNOOZE_LOAD;
        end else if (expire_s) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = RINGING;
        end
      end
      SNOOZE: begin
        if (arm_btn) begin
          state_nxt_s = IDLE;
        end else if (stop_btn) begin
          state_nxt_s = ARMED;
        end else if (expire_s) begin
          state_nxt_s = RINGING;
          load_s      = 1'b1;
          load_val_s  = RING_LOAD;
        end else begin
          state_nxt_s = SNOOZE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Beep phase: restart on entry to RINGING so the first second beeps.
  always_comb begin
    phase_nxt_s = phase_r;
    if ((state_nxt_s == RINGING) && (state_r != RINGING)) begin
      phase_nxt_s = 1'b0;
    end else if ((state_r == RINGING) && tick_1hz) begin
      phase_nxt_s = ~phase_r;
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // State, match history and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      match_q_r <= 1'b0;
      phase_r   <= 1'b0;
      armed_r   <= 1'b0;
      ringing_r <= 1'b0;
      buzzer_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      match_q_r <= match_s;
      phase_r   <= phase_nxt_s;
      armed_r   <= (state_nxt_s != IDLE);
      ringing_r <= (state_nxt_s == RINGING);
      buzzer_r  <= (state_nxt_s == RINGING) & ~phase_nxt_s;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: expected output words are queued as
// stimulus is applied and popped/compared after the DUT responds.
module tb_alarm_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_1hz = 1'b0;
  logic [19:0] cur_time = 20'd0;
  logic [19:0] alarm_time = 20'd0;
  logic        mode_btn = 1'b0;
  logic [1:0]  edit_btns = 2'b00;
  logic        arm_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic        snooze_btn = 1'b0;
  logic [1:0]  clk_edit_btns;
  logic [1:0]  alm_edit_btns;
  logic [1:0]  mode;
  logic        armed;
  logic        ringing;
  logic        buzzer;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [8:0] v;
  } exp_t;
  exp_t exp_q[$];

  alarm_ctrl #(.RING_SECS(60), .SNOOZE_SECS(300)) dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1hz      (tick_1hz),
    .cur_time      (cur_time),
    .alarm_time    (alarm_time),
    .mode_btn      (mode_btn),
    .edit_btns     (edit_btns),
    .arm_btn       (arm_btn),
    .stop_btn      (stop_btn),
    .snooze_btn    (snooze_btn),
    .clk_edit_btns (clk_edit_btns),
    .alm_edit_btns (alm_edit_btns),
    .mode          (mode),
    .armed         (armed),
    .ringing       (ringing),
    .buzzer        (buzzer)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] tm(input int h, input int m, input int s);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    h1 = 4'(h / 10); h0 = 4'(h % 10);
    m1 = 4'(m / 10); m0 = 4'(m % 10);
    s1 = 4'(s / 10); s0 = 4'(s % 10);
    return {h1[1:0], h0, m1[2:0], m0, s1[2:0], s0};
  endfunction

  function automatic logic [8:0] ev(input logic [1:0] m, input logic a, input logic r,
                                    input logic b, input logic [1:0] ce, input logic [1:0] ae);
    return {m, a, r, b, ce, ae};
  endfunction

  function automatic logic [8:0] obs_f();
    return {mode, armed, ringing, buzzer, clk_edit_btns, alm_edit_btns};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    mode_btn = 1'b0; arm_btn = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
    tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    exp_q.push_back('{name: "reset", v: ev(2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    edit_btns = 2'b11;
    exp_q.push_back('{name: "reset_route", v: ev(2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00)});
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    edit_btns = 2'b00;
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_mode();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      logic [1:0] m;
      m = 2'((i + 1) % 3);
      mode_btn = 1'b1;
      cycle();
      edit_btns = 2'b01;
      exp_q.push_back('{name: "mode_route", v: ev(m, 1'b0, 1'b0, 1'b0,
                        (m == 2'd1) ? 2'b01 : 2'b00, (m == 2'd2) ? 2'b01 : 2'b00)});
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs_f() !== e.v) begin errors++; $display("FAIL %s step %0d got %b want %b", e.name, i, obs_f(), e.v); end
      edit_btns = 2'b00;
    end
  endtask

  task automatic test_ring();
    exp_t e;
    alarm_time = tm(0, 1, 0);
    cur_time   = tm(0, 0, 59);
    arm_btn    = 1'b1;
    exp_q.push_back('{name: "arm", v: ev(2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    cur_time = tm(0, 1, 0); tick_1hz = 1'b1;
    exp_q.push_back('{name: "ring_start", v: ev(2'd0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    for (int k = 1; k <= 60; k++) begin
      cur_time = (k < 60) ? tm(0, 1, k) : tm(0, 2, 0);
      tick_1hz = 1'b1;
      exp_q.push_back('{name: "ring_tick", v: ev(2'd0, 1'b1, k < 60, (k < 60) && (k % 2 == 0), 2'b00, 2'b00)});
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_f() !== e.v) begin errors++; $display("FAIL %s tick %0d got %b want %b", e.name, k, obs_f(), e.v); end
    end
  endtask

  task automatic test_snooze();
    exp_t e;
    cur_time = tm(0, 0, 59);
    cycle();
    cur_time = tm(0, 1, 0); tick_1hz = 1'b1;
    exp_q.push_back('{name: "snz_ring", v: ev(2'd0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    snooze_btn = 1'b1;
    exp_q.push_back('{name: "snooze", v: ev(2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    cur_time = tm(0, 1, 1);
    for (int k = 1; k <= 300; k++) begin
      tick_1hz = 1'b1;
      exp_q.push_back('{name: "snooze_tick", v: ev(2'd0, 1'b1, k == 300, k == 300, 2'b00, 2'b00)});
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_f() !== e.v) begin errors++; $display("FAIL %s tick %0d got %b want %b", e.name, k, obs_f(), e.v); end
    end
  endtask

  task automatic test_stop();
    exp_t e;
    stop_btn = 1'b1;
    exp_q.push_back('{name: "stop", v: ev(2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    cur_time = tm(0, 0, 59);
    cycle();
    cur_time = tm(0, 1, 0); tick_1hz = 1'b1;
    exp_q.push_back('{name: "stop_ring", v: ev(2'd0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    stop_btn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back('{name: "no_retrigger", v: ev(2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00)});
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_f() !== e.v) begin errors++; $display("FAIL %s cyc %0d got %b want %b", e.name, k, obs_f(), e.v); end
    end
    cur_time = tm(0, 1, 1); tick_1hz = 1'b1;
    exp_q.push_back('{name: "after_match", v: ev(2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    cur_time = tm(0, 1, 0); tick_1hz = 1'b1;
    exp_q.push_back('{name: "rematch", v: ev(2'd0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
  endtask

  task automatic test_coincide();
    exp_t e;
    stop_btn = 1'b1; snooze_btn = 1'b1;
    exp_q.push_back('{name: "stop_snooze", v: ev(2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    mode_btn = 1'b1;
    cycle();
    mode_btn = 1'b1;
    exp_q.push_back('{name: "to_set_alm", v: ev(2'd2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    cur_time = tm(0, 1, 1);
    cycle();
    cur_time = tm(0, 1, 0); tick_1hz = 1'b1;
    exp_q.push_back('{name: "ring_in_set_alm", v: ev(2'd2, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    arm_btn = 1'b1; stop_btn = 1'b1;
    exp_q.push_back('{name: "arm_stop", v: ev(2'd2, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    mode_btn = 1'b1;
    exp_q.push_back('{name: "mode_wrap", v: ev(2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
  endtask

  task automatic test_reset_snooze();
    exp_t e;
    cur_time = tm(0, 1, 1); arm_btn = 1'b1;
    cycle();
    cur_time = tm(0, 1, 0); tick_1hz = 1'b1;
    cycle();
    snooze_btn = 1'b1;
    exp_q.push_back('{name: "rs_snooze", v: ev(2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    cur_time = tm(0, 1, 1);
    for (int k = 0; k < 150; k++) begin
      tick_1hz = 1'b1;
      cycle();
    end
    checks++;
    if (dut.u_cnt.count_r !== 9'd150) begin
      errors++; $display("FAIL snooze_count got %0d want 150", dut.u_cnt.count_r);
    end
    reset = 1'b1;
    exp_q.push_back('{name: "reset_in_snooze", v: ev(2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    checks++;
    if (dut.u_cnt.count_r !== 9'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", dut.u_cnt.count_r);
    end
    reset = 1'b0;
    cur_time = tm(0, 1, 0); tick_1hz = 1'b1;
    exp_q.push_back('{name: "match_disarmed", v: ev(2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    cur_time = tm(0, 1, 1); arm_btn = 1'b1;
    exp_q.push_back('{name: "rearm", v: ev(2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
    cur_time = tm(0, 1, 0); tick_1hz = 1'b1;
    exp_q.push_back('{name: "rearm_ring", v: ev(2'd0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00)});
    cycle();
    e = exp_q.pop_front(); checks++;
    if (obs_f() !== e.v) begin errors++; $display("FAIL %s got %b want %b", e.name, obs_f(), e.v); end
  endtask

  initial begin
    alarm_time = tm(0, 1, 0);
    cur_time   = tm(0, 0, 30);
    test_reset();
    test_mode();
    test_ring();
    test_snooze();
    test_stop();
    test_coincide();
    test_reset_snooze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm sequencing controller for the alarm-clock top level. It routes the user's edit-button edges to either the timekeeping counter or the `alarm` register, and compares the running time against the set alarm time. On a match it runs the arm/ring/snooze state machine and drives the buzzer enable. It sits between the button edge detectors, the clock counter, the `alarm` block and the display mux.

## Interface
Parameters:
- `RING_SECS`, default 60: seconds of ringing before auto-stop.
- `SNOOZE_SECS`, default 300: snooze duration in seconds.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `tick_1hz`  in  1: one-cycle pulse once per second, aligned with `cur_time` updates.
- `cur_time`  in  20: running time as BCD hh:mm:ss, laid out as {H1[19:18], H0[17:14], M1[13:11], M0[10:7], S1[6:4], S0[3:0]}.
- `alarm_time`  in  20: alarm time from `alarm`, in the same layout.
- `mode_btn`  in  1: edge; cycles the edit mode.
- `edit_btns`  in  2: edges; hours (bit 1) and minutes (bit 0).
- `arm_btn`  in  1: edge; toggles armed/disarmed.
- `stop_btn`  in  1: edge; stops ringing or snooze.
- `snooze_btn`  in  1: edge; snoozes while ringing.
- `clk_edit_btns`  out  2: edit edges routed to the clock counter.
- `alm_edit_btns`  out  2: edit edges routed to `alarm`.
- `mode`  out  2: 0 = RUN, 1 = SET_CLK, 2 = SET_ALM; also used as the display select.
- `armed`  out  1: high in ARMED, RINGING or SNOOZE.
- `ringing`  out  1: high in RINGING.
- `buzzer`  out  1: ringing gated by a 1 Hz beep phase.

## Operation
- Mode register:
  - `mode_btn` steps RUN → SET_CLK → SET_ALM → RUN.
  - Value 3 is never produced.
- Edit routing is combinational from `mode`:
  - `clk_edit_btns = edit_btns` when SET_CLK, else 0.
  - `alm_edit_btns = edit_btns` when SET_ALM, else 0.
  - In RUN, edits are dropped.
- Match condition:
  - `match = (cur_time == alarm_time)`, full 20-bit compare.
  - `match_q` is the registered copy of `match`.
  - `hit = match & ~match_q` (rising edge only), so a stop inside the matching second does not retrigger.
- Alarm FSM states: IDLE, ARMED, RINGING, SNOOZE.
  - IDLE: `arm_btn` → ARMED.
  - ARMED:
    - `arm_btn` → IDLE.
    - `hit` → RINGING, loading the second counter with RING_SECS.
  - RINGING:
    - `arm_btn` → IDLE.
    - `stop_btn` → ARMED.
    - `snooze_btn` → SNOOZE, loading SNOOZE_SECS.
    - Counter expiry → ARMED.
  - SNOOZE:
    - `arm_btn` → IDLE.
    - `stop_btn` → ARMED.
    - Counter expiry → RINGING, reloading RING_SECS.
    - `hit` is ignored.
- Priority when inputs coincide in one cycle: `arm_btn` > `stop_btn` > `snooze_btn` > `hit`/expiry.
  - Example: stop and snooze together while RINGING → ARMED.
- The alarm triggers in any `mode`, including SET_ALM.
- Second counter:
  - Width is `$clog2(max(RING_SECS, SNOOZE_SECS)+1)`.
  - Decrements on `tick_1hz` while in RINGING or SNOOZE.
  - Expiry is `tick_1hz` with counter == 1; a load of N therefore expires on the Nth tick.
  - A load and a tick in the same cycle: the load wins.
- Beep phase register:
  - Cleared on entry to RINGING.
  - Toggles on `tick_1hz` while RINGING.
  - `buzzer = ringing & ~phase`, so the buzzer is on during the first second.

## Timing
- Reset values:
  - mode = RUN, state = IDLE, counter = 0, `match_q` = 0, phase = 0.
  - Outputs: `armed` = `ringing` = `buzzer` = 0, routed edit buses = 0.
- Reset is sampled every cycle. Reset mid-ring or mid-snooze returns to IDLE on the next edge.
- Edit routing has zero latency (combinational). `mode` changes one cycle after `mode_btn`.
- `ringing`, `armed` and `buzzer` are registered: high one cycle after the `hit` cycle.
- Button responses take effect one cycle after the edge.
- All button inputs are assumed to be single-cycle pulses.

## Structure
- Shared package `alarm_pkg` holds:
  - `state_t` enum {IDLE, ARMED, RINGING, SNOOZE}.
  - `mode_t` enum {RUN, SET_CLK, SET_ALM}.
  - BCD field slice constants for the 20-bit time word.
- One natural sub-module, `sec_countdown`: a loadable, tick-decrementing counter with an `expire` pulse, parameterized by width.
- The FSM, mode register and routing stay in `alarm_ctrl`.

## Test plan
- Reset, then `mode_btn` ×3 with `edit_btns=2'b01` each step:
  - `clk_edit_btns` pulses only in SET_CLK.
  - `alm_edit_btns` pulses only in SET_ALM.
  - `mode` returns to 0.
- Arm, then `alarm_time=00:01:00` and `cur_time` stepping 00:00:59 → 00:01:00:
  - `ringing` = 1 one cycle later; `buzzer` = 1.
  - `buzzer` toggles on each tick.
  - With RING_SECS=60, `ringing` falls after the 60th tick; state returns to ARMED.
- Ringing, then `snooze_btn`: `ringing` = 0 and `armed` = 1. After 300 ticks, `ringing` = 1 again.
- Ringing, then `stop_btn` while `cur_time` still equals the alarm: no retrigger within that second, nor on later cycles until the next 24 h match.
- Same-cycle `stop_btn` + `snooze_btn` while RINGING → ARMED. Same-cycle `arm_btn` + `stop_btn` → IDLE with `armed` = 0.
- Reset asserted during SNOOZE with the counter at 150 → IDLE, counter 0. A subsequent match does not ring until re-armed.
